// File: rtl/dsp_overpack_seq.sv
// dsp_overpack_seq: runs one packed dot-product job through an external
// (A + D) * B + C DSP slice. Operand words are fetched from a local memory,
// split into weight/activation fields, packed onto the DSP ports, and the raw
// 48-bit products of every beat are summed in fabric. Field unpacking of the
// packed sum happens downstream.
//
// Result handshake: result is presented with result_valid; a transfer happens
// on any rising CLK edge where result_valid and result_ready are both 1.
// While result_valid is 1 and no transfer has happened, result and
// result_valid stay unchanged. result_ready may be high before result_valid
// rises; the transfer then happens on the first edge with result_valid high.
module dsp_overpack_seq #(
    parameter int VEC_LEN = 16,
    parameter int ADDR_W  = 8,
    parameter int DSP_LAT = 3
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [19:0]       mem_rdata,
    output logic [24:0]       dsp_A,
    output logic [17:0]       dsp_B,
    output logic [24:0]       dsp_D,
    output logic [47:0]       dsp_C,
    input  logic [47:0]       dsp_P,
    output logic [47:0]       result,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   ret_cnt_q, ret_cnt_d;
    logic               ret_done_q, ret_done_d;
    logic [47:0]        acc_q, acc_d;
    logic [24:0]        pk_a_q, pk_a_d;
    logic [17:0]        pk_b_q, pk_b_d;
    logic [24:0]        pk_d_q, pk_d_d;
    // rd_tag marks the cycle in which mem_rdata carries a beat
    logic               rd_tag_q, rd_tag_d;
    // vld[0] travels with the pack registers; vld[DSP_LAT-1] marks the edge at
    // which dsp_P belongs to a beat of this job
    logic [DSP_LAT-1:0] vld_q, vld_d;
    logic [47:0]        result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               done_q, done_d;
    logic               rd_en_c;
    logic [ADDR_W-1:0]  rd_addr_c;

    // Field split of the operand word
    logic [3:0] w1, w0, a2, a1, a0;
    assign {w1, w0, a2, a1, a0} = mem_rdata;

    // Next-state, datapath and read-port logic
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        issue_cnt_d    = issue_cnt_q;
        ret_cnt_d      = ret_cnt_q;
        acc_d          = acc_q;
        pk_a_d         = pk_a_q;
        pk_b_d         = pk_b_q;
        pk_d_d         = pk_d_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        done_d         = 1'b0;
        rd_en_c        = 1'b0;
        rd_addr_c      = '0;
        // The all-returned compare is registered so the result load sees a
        // flop rather than the counter compare chain.
        ret_done_d     = (state_q == DRAIN) && (ret_cnt_q == CNT_W'(VEC_LEN));

        // Pack registers only change when a beat is actually on mem_rdata
        if (rd_tag_q) begin
            pk_a_d = {{21{w0[3]}}, w0};
            pk_b_d = {2'b00, a2, 2'b00, a1, 2'b00, a0};
            pk_d_d = {{3{w1[3]}}, w1, 18'd0};
        end

        vld_d[0] = rd_tag_q;
        for (int i = 1; i < DSP_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        // Only tagged products are accumulated
        if (vld_q[DSP_LAT-1]) begin
            acc_d     = acc_q + dsp_P;
            ret_cnt_d = ret_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    acc_d       = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                rd_en_c     = 1'b1;
                rd_addr_c   = base_q + ADDR_W'(issue_cnt_q);
                issue_cnt_d = issue_cnt_q + CNT_W'(1);
                if (issue_cnt_q == CNT_W'(VEC_LEN - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ret_done_q) begin
                    result_d       = acc_q;
                    result_valid_d = 1'b1;
                    done_d         = 1'b1;
                    state_d        = OUT;
                end
            end
            OUT: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_tag_d = rd_en_c;
    end

    // State and datapath registers; reset aborts any job in flight
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q        <= IDLE;
            base_q         <= '0;
            issue_cnt_q    <= '0;
            ret_cnt_q      <= '0;
            ret_done_q     <= 1'b0;
            acc_q          <= '0;
            pk_a_q         <= '0;
            pk_b_q         <= '0;
            pk_d_q         <= '0;
            rd_tag_q       <= 1'b0;
            vld_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            issue_cnt_q    <= issue_cnt_d;
            ret_cnt_q      <= ret_cnt_d;
            ret_done_q     <= ret_done_d;
            acc_q          <= acc_d;
            pk_a_q         <= pk_a_d;
            pk_b_q         <= pk_b_d;
            pk_d_q         <= pk_d_d;
            rd_tag_q       <= rd_tag_d;
            vld_q          <= vld_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign mem_rd_en    = rd_en_c;
    assign mem_addr     = rd_addr_c;
    assign dsp_A        = pk_a_q;
    assign dsp_B        = pk_b_q;
    assign dsp_D        = pk_d_q;
    assign dsp_C        = 48'd0;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dsp_overpack_seq.sv
// Bench for dsp_overpack_seq: three instances (VEC_LEN 1, 4, 16), each with
// an operand memory model and a DSP model of latency 3.
module tb_dsp_overpack_seq;

    localparam int NDUT = 3;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        start        [NDUT];
    logic [7:0]  base_addr    [NDUT];
    logic        result_ready [NDUT];
    logic        busy         [NDUT];
    logic        done         [NDUT];
    logic        mem_rd_en    [NDUT];
    logic [7:0]  mem_addr     [NDUT];
    logic [24:0] dsp_A        [NDUT];
    logic [17:0] dsp_B        [NDUT];
    logic [24:0] dsp_D        [NDUT];
    logic [47:0] dsp_C        [NDUT];
    logic [47:0] result       [NDUT];
    logic        result_valid [NDUT];

    logic [19:0] mem [NDUT][256];
    int          done_cnt [NDUT];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [19:0] word;
        logic [24:0] a;
        logic [17:0] b;
        logic [24:0] d;
        logic [47:0] res;
        bit          early_rdy;
    } vec_t;

    vec_t tbl [5];

    always #5 CLK = ~CLK;

    function automatic logic [47:0] dsp_f(input logic [24:0] a, input logic [17:0] b,
                                          input logic [24:0] d, input logic [47:0] c);
        logic [47:0] s;
        s = {{23{a[24]}}, a} + {{23{d[24]}}, d};
        return s * {30'd0, b} + c;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int VL = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        logic [19:0] rdata;
        logic [47:0] p_s0 = 48'hDEAD_BEEF_0001;
        logic [47:0] p_s1 = 48'hDEAD_BEEF_0002;

        // Operand memory: registered read, junk when not read
        always @(posedge CLK) begin
            if (mem_rd_en[g]) rdata <= mem[g][mem_addr[g]];
            else              rdata <= 20'hA5A5A;
        end

        // DSP: inputs launched at edge k give P sampled at edge k+3
        always @(posedge CLK) begin
            p_s0 <= dsp_f(dsp_A[g], dsp_B[g], dsp_D[g], dsp_C[g]);
            p_s1 <= p_s0;
        end

        dsp_overpack_seq #(.VEC_LEN(VL), .ADDR_W(8), .DSP_LAT(3)) u_dut (
            .CLK          (CLK),
            .RSTN         (RSTN),
            .start        (start[g]),
            .base_addr    (base_addr[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .mem_rd_en    (mem_rd_en[g]),
            .mem_addr     (mem_addr[g]),
            .mem_rdata    (rdata),
            .dsp_A        (dsp_A[g]),
            .dsp_B        (dsp_B[g]),
            .dsp_D        (dsp_D[g]),
            .dsp_C        (dsp_C[g]),
            .dsp_P        (p_s1),
            .result       (result[g]),
            .result_valid (result_valid[g]),
            .result_ready (result_ready[g])
        );
    end

    always @(negedge CLK) begin
        for (int d = 0; d < NDUT; d++) begin
            if (done[d] === 1'b1) done_cnt[d] <= done_cnt[d] + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk_zero_outputs(input int d, input string tag);
        chk({tag, "_busy"},   64'(busy[d]),         64'(0));
        chk({tag, "_done"},   64'(done[d]),         64'(0));
        chk({tag, "_rd_en"},  64'(mem_rd_en[d]),    64'(0));
        chk({tag, "_addr"},   64'(mem_addr[d]),     64'(0));
        chk({tag, "_dsp_A"},  64'(dsp_A[d]),        64'(0));
        chk({tag, "_dsp_B"},  64'(dsp_B[d]),        64'(0));
        chk({tag, "_dsp_D"},  64'(dsp_D[d]),        64'(0));
        chk({tag, "_dsp_C"},  64'(dsp_C[d]),        64'(0));
        chk({tag, "_result"}, 64'(result[d]),       64'(0));
        chk({tag, "_rvalid"}, 64'(result_valid[d]), 64'(0));
    endtask

    // One job: optional per-cycle read checks, latency, result, optional
    // backpressure with a start pulse during OUT, then the handshake.
    task automatic run_job(input int d, input logic [7:0] base, input int nchk,
                           input int exp_lat, input logic [47:0] exp_res,
                           input int hold, input bit early_rdy);
        int n;
        int dc0;
        logic [7:0] ea;
        dc0 = done_cnt[d];
        @(negedge CLK);
        start[d]        = 1'b1;
        base_addr[d]    = base;
        result_ready[d] = early_rdy;
        @(posedge CLK); #1;
        start[d] = 1'b0;
        chk("busy_after_start", 64'(busy[d]), 64'(1));
        n = 0;
        while (result_valid[d] !== 1'b1 && n < 100) begin
            if (n < nchk) begin
                ea = base + 8'(n);
                chk("rd_en", 64'(mem_rd_en[d]), 64'(1));
                chk("rd_addr", 64'(mem_addr[d]), 64'(ea));
            end
            @(posedge CLK); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        chk("result", 64'(result[d]), 64'(exp_res));
        chk("done_pulse", 64'(done[d]), 64'(1));
        if (nchk > 0) chk("rd_en_off", 64'(mem_rd_en[d]), 64'(0));
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            start[d]     = (k == 1);
            base_addr[d] = 8'h55;
            @(posedge CLK); #1;
            chk("hold_rvalid", 64'(result_valid[d]), 64'(1));
            chk("hold_result", 64'(result[d]), 64'(exp_res));
            chk("hold_busy", 64'(busy[d]), 64'(1));
            chk("hold_rd_en", 64'(mem_rd_en[d]), 64'(0));
            chk("hold_done", 64'(done[d]), 64'(0));
        end
        start[d] = 1'b0;
        if (!early_rdy) begin
            @(negedge CLK);
            result_ready[d] = 1'b1;
        end
        @(posedge CLK); #1;
        result_ready[d] = 1'b0;
        chk("rvalid_clear", 64'(result_valid[d]), 64'(0));
        chk("idle_after", 64'(busy[d]), 64'(0));
        chk("done_once", 64'(done_cnt[d] - dc0), 64'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc_before;

        // {word {w1,w0,a2,a1,a0}, dsp_A, dsp_B, dsp_D, result, early_ready}
        tbl[0] = '{20'h01321, 25'h0000001, 18'h03081, 25'h0000000, 48'h0000_0000_3081, 1'b0};
        tbl[1] = '{20'h0F001, 25'h1FFFFFF, 18'h00001, 25'h0000000, 48'hFFFF_FFFF_FFFF, 1'b0};
        tbl[2] = '{20'h10001, 25'h0000000, 18'h00001, 25'h0040000, 48'h0000_0004_0000, 1'b0};
        tbl[3] = '{20'hF7FFF, 25'h0000007, 18'h0F3CF, 25'h1FC0000, 48'hFFFC_30CA_AAA9, 1'b0};
        tbl[4] = '{20'h23100, 25'h0000003, 18'h01000, 25'h0080000, 48'h0000_8000_3000, 1'b1};

        for (int d = 0; d < NDUT; d++) begin
            for (int a = 0; a < 256; a++) mem[d][a] = 20'h0;
            start[d]        = 1'b0;
            base_addr[d]    = 8'h00;
            result_ready[d] = 1'b0;
        end
        for (int i = 0; i < 5; i++) mem[0][8'h40 + i] = tbl[i].word;
        mem[1][8'h10] = 20'h11001; mem[1][8'h11] = 20'h11001;
        mem[1][8'h12] = 20'h11001; mem[1][8'h13] = 20'h11001;
        mem[1][8'hFE] = 20'h11001; mem[1][8'hFF] = 20'h11001;
        mem[1][8'h00] = 20'h11001; mem[1][8'h01] = 20'h11001;
        for (int i = 0; i < 4; i++) mem[1][8'h20 + i] = 20'h02010;
        for (int i = 0; i < 16; i++) begin
            mem[2][i]         = 20'h11000 | 20'(i);
            mem[2][8'h80 + i] = 20'hF7FFF;
        end

        // Reset state
        RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        for (int d = 0; d < NDUT; d++) chk_zero_outputs(d, "reset");
        @(negedge CLK);
        RSTN = 1'b1;

        // Single-beat vectors: result, latency 1+3+3, pack registers held
        for (int i = 0; i < 5; i++) begin
            run_job(0, 8'h40 + 8'(i), 1, 7, tbl[i].res, 0, tbl[i].early_rdy);
            chk("vec_dsp_A", 64'(dsp_A[0]), 64'(tbl[i].a));
            chk("vec_dsp_B", 64'(dsp_B[0]), 64'(tbl[i].b));
            chk("vec_dsp_D", 64'(dsp_D[0]), 64'(tbl[i].d));
        end

        // Four-beat accumulation, plain and wrapping addresses; the wrapping
        // job sees 5 cycles of backpressure with a start pulse during OUT
        run_job(1, 8'h10, 4, 10, 48'h0000_0010_0004, 0, 1'b0);
        run_job(1, 8'hFE, 4, 10, 48'h0000_0010_0004, 5, 1'b0);
        // Restart in the first IDLE cycle after the handshake
        run_job(1, 8'h20, 4, 10, 48'h0000_0000_0200, 0, 1'b0);

        // Mid-job reset in the 3rd ISSUE cycle of a 16-beat job
        dc_before = done_cnt[2];
        @(negedge CLK);
        start[2]     = 1'b1;
        base_addr[2] = 8'h80;
        @(posedge CLK); #1;
        start[2] = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("mid_rd_en", 64'(mem_rd_en[2]), 64'(1));
        chk("mid_addr", 64'(mem_addr[2]), 64'(8'h82));
        RSTN = 1'b0;
        #1;
        chk_zero_outputs(2, "midrst");
        repeat (2) @(posedge CLK);
        #1;
        chk("midrst_busy_held", 64'(busy[2]), 64'(0));
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("midrst_no_done", 64'(done_cnt[2] - dc_before), 64'(0));
        chk("midrst_idle", 64'(busy[2]), 64'(0));
        run_job(2, 8'h00, 16, 22, 48'h0000_01E0_0078, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
